sum_display_mux: RTL

// Parametrised successor to the lab 2 switch-sum LED block. Sums NCH unsigned
// W-bit switch operands onto a registered LED bus. Time-multiplexes one hex

---
 rtl/sum_display_mux_if.sv | 17 +
 rtl/sum_display_mux.sv | 124 ++++++++++++
 2 files changed

// File: rtl/sum_display_mux_if.sv
// Board-side signal bundle for sum_display_mux: switch operands in; LED sum,
// segment, anode and strobe out.
interface sum_display_mux_if #(
    parameter int NCH = 2,
    parameter int W   = 4
);
    localparam int LED_W = (NCH > 1) ? W + $clog2(NCH) : W;

    logic [NCH*W-1:0] switches;
    logic [LED_W-1:0] leds;
    logic [6:0]       seg;
    logic [NCH-1:0]   anode;
    logic             digit_strobe;

    modport master (output switches, input leds, seg, anode, digit_strobe);
    modport slave  (input switches, output leds, seg, anode, digit_strobe);
endinterface

// File: rtl/sum_display_mux.sv
// Sums NCH switch operands onto a registered LED bus and scans one hex digit
// per operand across a shared seven-segment display with blanking between digits.
module sum_display_mux #(
    parameter int NCH     = 2,
    parameter int W       = 4,
    parameter int REFRESH = 10000,
    parameter int BLANK   = 16
) (
    input  logic               clk,
    input  logic               reset,
    sum_display_mux_if.slave   bus
);
    localparam int LED_W   = (NCH > 1) ? W + $clog2(NCH) : W;
    localparam int IDX_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_MAX = (REFRESH > BLANK) ? REFRESH : BLANK;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [NCH*W-1:0] sync1_q, sync2_q;
    logic [LED_W-1:0] leds_d, leds_q;
    state_t           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [IDX_W-1:0] idx_d, idx_q;
    logic [3:0]       digit_d, digit_q;
    logic [6:0]       seg_d, seg_q;
    logic [NCH-1:0]   anode_d, anode_q;
    logic             strobe_d, strobe_q;
    logic             enter_show;
    logic [3:0]       sel_digit;

    always_comb begin
        leds_d = '0;
        for (int k = 0; k < NCH; k++) begin
            leds_d = leds_d + LED_W'(sync2_q[k*W +: W]);
        end
    end

    // Outputs are derived from the next state so the registered copies always
    // agree with the state register they sit beside.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        digit_d    = digit_q;
        enter_show = 1'b0;
        sel_digit  = '0;
        case (state_q)
            ST_BLANK: begin
                if (BLANK == 0 || cnt_q == CNT_W'(BLANK - 1)) begin
                    state_d    = ST_SHOW;
                    cnt_d      = '0;
                    enter_show = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHOW: begin
                if (cnt_q == CNT_W'(REFRESH - 1)) begin
                    idx_d = (idx_q == IDX_W'(NCH - 1)) ? '0 : idx_q + IDX_W'(1);
                    cnt_d = '0;
                    if (BLANK == 0) begin
                        state_d    = ST_SHOW;
                        enter_show = 1'b1;
                    end else begin
                        state_d = ST_BLANK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_BLANK;
        endcase
        for (int k = 0; k < NCH; k++) begin
            if (idx_d == IDX_W'(k)) sel_digit = 4'(sync2_q[k*W +: W]);
        end
        if (enter_show) digit_d = sel_digit;
        strobe_d = enter_show;
        seg_d    = (state_d == ST_SHOW) ? hex7(digit_d) : 7'h7F;
        anode_d  = (state_d == ST_SHOW) ? ~(NCH'(1) << idx_d) : '1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            leds_q   <= '0;
            state_q  <= ST_BLANK;
            cnt_q    <= '0;
            idx_q    <= '0;
            digit_q  <= '0;
            seg_q    <= 7'h7F;
            anode_q  <= '1;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= bus.switches;
            sync2_q  <= sync1_q;
            leds_q   <= leds_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            digit_q  <= digit_d;
            seg_q    <= seg_d;
            anode_q  <= anode_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.leds         = leds_q;
    assign bus.seg          = seg_q;
    assign bus.anode        = anode_q;
    assign bus.digit_strobe = strobe_q;
endmodule
